dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port DataMemory between two requesters: port 0, the pipeline
//  MEM stage, and port 1, the program/data loader (UART/debug DMA).
//  Port 0 has fixed priority. A starvation counter forces a grant to port 1
//  after MAX_WAIT consecutive lost cycles.
//  The arbiter drives the memory's Address/Write_data/MemRead/MemWrite pins,
//  registers read data and returns it with a one-cycle valid pulse.
// PARAMETERS
//  ADDR_W        30  word-address width, matches DataMemory Address
//  DATA_W        32  data width
//  RAM_SIZE_BIT  5   log2 of implemented words; higher address bits must be 0
//  MAX_WAIT      4   lost cycles before port 1 is forced; legal range 1..(2^CNT_W)-1
//  CNT_W         3   starvation counter width
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-high
//  req0/req1      in   1       request, held until granted
//  we0/we1        in   1       1=write, 0=read; valid with req
//  addr0/addr1    in   ADDR_W  word address; valid with req
//  wdata0/wdata1  in   DATA_W  write data; valid with req&we
//  gnt0/gnt1      out  1       combinational grant; transfer occurs at edge where req&gnt
//  rdata0/rdata1  out  DATA_W  registered read data; held until next read on that port
//  rvalid0/1      out  1       1-cycle pulse, cycle after a granted read
//  err0/err1      out  1       1-cycle pulse, cycle after a granted out-of-range access
//  mem_addr       out  ADDR_W  to DataMemory Address
//  mem_wdata      out  DATA_W  to DataMemory Write_data
//  mem_rd         out  1       to DataMemory MemRead
//  mem_wr         out  1       to DataMemory MemWrite
//  mem_rdata      in   DATA_W  from DataMemory Read_data (combinational)
//  starve_cnt     out  CNT_W   debug: current starvation count
// BEHAVIOUR
//  Grant, evaluated combinationally each cycle, first match wins:
//   - force = req1 && starve_cnt==MAX_WAIT -> gnt1
//   - req0 -> gnt0
//   - req1 -> gnt1
//   - otherwise no grant
//  At most one gnt is high per cycle.
//  Memory drive:
//   - mem_addr/mem_wdata = the granted port's fields; 0 when idle
//   - mem_rd = granted & !we
//   - mem_wr = granted & we
//   - A write commits at the same edge; zero added latency.
//  Reads:
//   - mem_rdata is captured into rdataN at the edge of the granted cycle.
//   - rvalidN=1 the next cycle only; read latency is 1 cycle.
//   - Back-to-back reads on one port give one rvalid per cycle.
//  Range check: granted access with addr[ADDR_W-1:RAM_SIZE_BIT]!=0:
//   - Still consumes the grant.
//   - Write is suppressed; mem_wr=0.
//   - Read returns 0 with rvalid=1.
//   - errN pulses in the same cycle as rvalid would.
//  Starvation counter, registered:
//   - Clears when gnt1 or !req1.
//   - +1 when req1 && !gnt1, saturating at MAX_WAIT.
//   - Forced grant clears it, so port 0 waits exactly one cycle per MAX_WAIT+1.
//  Simultaneous read-after-write to the same address from the two ports:
//   - Order follows grant order.
//   - The later read sees the written value.
//  Reset:
//   - Asynchronous. Clears starve_cnt, rdata0/1, rvalid0/1 and err0/1 to 0.
//   - gnt, mem_rd and mem_wr are forced to 0 while reset=1.
//   - A transfer pending at the reset edge is dropped, with no write and no rvalid.
//   - First grant is possible in the first cycle after reset deasserts.
// TESTING
//  1. Reset, then req1 read of addr 3 alone -> gnt1=1 same cycle; next cycle rvalid1=1, rdata1=0x4F.
//  2. req0 write 0xDEADBEEF @16, then read @16 -> rvalid0 then rdata0=0xDEADBEEF; no rvalid on write.
//  3. req0 and req1 held high continuously, MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on 5th, pattern repeats; starve_cnt 0,1,2,3,4,0.
//  4. Same cycle: port0 write 0x55 @20 (granted), port1 read @20 -> port1 granted next cycle, rdata1=0x55.
//  5. req0 write @0x40 (out of range) -> mem_wr=0, err0 pulse next cycle; word @0 unchanged (0x3F).
//  6. Assert reset during a granted port1 write of 0x12 @17 -> no write; @17 reads 0; rvalid/err/starve_cnt all 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory.
// Port 0 (pipeline MEM stage) has fixed priority; port 1 (loader) is forced
// through after MAX_WAIT consecutive lost cycles. Read data is registered and
// returned with a one-cycle valid pulse.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RAM_SIZE_BIT = 5,
    parameter int unsigned MAX_WAIT     = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  starve_cnt
);

    localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;
    logic              err0_q, err1_q;

    logic              force1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              granted;
    logic              out_of_range;

    // Grant decision and memory pin drive; all grants are held off during reset.
    always_comb begin
        force1    = req1 && (starve_cnt_q == MaxWaitC);
        gnt1      = !reset && req1 && (force1 || !req0);
        gnt0      = !reset && req0 && !force1;
        granted   = gnt0 || gnt1;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end else if (gnt0) begin
            sel_we    = we0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end
        out_of_range = sel_addr[ADDR_W-1:RAM_SIZE_BIT] != '0;
        mem_addr     = sel_addr;
        mem_wdata    = sel_wdata;
        mem_rd       = granted && !sel_we;
        // Out-of-range writes still consume the grant but never reach memory.
        mem_wr       = granted && sel_we && !out_of_range;
    end

    // Starvation counter next state: saturates at MAX_WAIT, cleared by a grant or no request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req1 || gnt1) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != MaxWaitC) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Registered read data, valid/error pulses and starvation count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rvalid0_q    <= gnt0 && !we0;
            rvalid1_q    <= gnt1 && !we1;
            err0_q       <= gnt0 && out_of_range;
            err1_q       <= gnt1 && out_of_range;
            if (gnt0 && !we0) begin
                rdata0_q <= out_of_range ? '0 : mem_rdata;
            end
            if (gnt1 && !we1) begin
                rdata1_q <= out_of_range ? '0 : mem_rdata;
            end
        end
    end

    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DataMemory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [29:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;
    logic [2:0]  starve_cnt;

    logic        mem_init;
    logic [31:0] mem [0:31];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // DataMemory model: combinational read, write at the edge, preloadable contents.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h3F;
            mem[3] <= 32'h4F;
        end else if (mem_wr) begin
            mem[mem_addr[4:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[4:0]];

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .err0       (err0),
        .err1       (err1),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .starve_cnt (starve_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        idle();
        reset    = 1;
        mem_init = 1;
        tick();
        tick();
        mem_init = 0;

        // Reset state: a request during reset gets no grant and drives nothing.
        req0 = 1; addr0 = 30'd1;
        #1;
        chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_starve", {29'b0, starve_cnt}, 32'd0);
        chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        chk("rst_err", {30'b0, err1, err0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        idle();
        reset = 0;

        // 1: port 1 read of addr 3 alone.
        req1 = 1; addr1 = 30'd3;
        #1;
        chk("t1_gnt1", {31'b0, gnt1}, 32'd1);
        chk("t1_gnt0", {31'b0, gnt0}, 32'd0);
        chk("t1_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("t1_mem_addr", {2'b0, mem_addr}, 32'd3);
        tick();
        idle();
        chk("t1_rvalid1", {31'b0, rvalid1}, 32'd1);
        chk("t1_rdata1", rdata1, 32'h4F);
        tick();
        chk("t1_rvalid1_pulse", {31'b0, rvalid1}, 32'd0);
        chk("t1_rdata1_held", rdata1, 32'h4F);

        // 2: port 0 write then read of addr 16.
        req0 = 1; we0 = 1; addr0 = 30'd16; wdata0 = 32'hDEADBEEF;
        #1;
        chk("t2_mem_wr", {31'b0, mem_wr}, 32'd1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        we0 = 0;
        chk("t2_no_rvalid_wr", {31'b0, rvalid0}, 32'd0);
        tick();
        idle();
        chk("t2_rvalid0", {31'b0, rvalid0}, 32'd1);
        chk("t2_rdata0", rdata0, 32'hDEADBEEF);
        tick();

        // 3: both ports held, port 1 forced every fifth cycle.
        req0 = 1; addr0 = 30'd1; req1 = 1; addr1 = 30'd2;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t3_cnt_%0d", i), {29'b0, starve_cnt}, 32'(i % 5));
            chk($sformatf("t3_gnt1_%0d", i), {31'b0, gnt1}, {31'b0, (i % 5) == 4});
            chk($sformatf("t3_gnt0_%0d", i), {31'b0, gnt0}, {31'b0, (i % 5) != 4});
            tick();
        end
        idle();
        tick();

        // 4: port 0 write 0x55 @20 wins, port 1 read @20 follows and sees it.
        req0 = 1; we0 = 1; addr0 = 30'd20; wdata0 = 32'h55;
        req1 = 1; addr1 = 30'd20;
        #1;
        chk("t4_gnt0_first", {30'b0, gnt1, gnt0}, 32'd1);
        tick();
        req0 = 0; we0 = 0;
        #1;
        chk("t4_gnt1_second", {30'b0, gnt1, gnt0}, 32'd2);
        tick();
        idle();
        chk("t4_rvalid1", {31'b0, rvalid1}, 32'd1);
        chk("t4_rdata1", rdata1, 32'h55);
        tick();

        // 5: out-of-range write is suppressed and flagged.
        req0 = 1; we0 = 1; addr0 = 30'h40; wdata0 = 32'h99;
        #1;
        chk("t5_gnt0", {31'b0, gnt0}, 32'd1);
        chk("t5_mem_wr", {31'b0, mem_wr}, 32'd0);
        tick();
        we0 = 0; addr0 = 30'd0;
        chk("t5_err0", {31'b0, err0}, 32'd1);
        chk("t5_no_rvalid", {31'b0, rvalid0}, 32'd0);
        tick();
        idle();
        chk("t5_err0_pulse", {31'b0, err0}, 32'd0);
        chk("t5_word0", rdata0, 32'h3F);
        // Out-of-range read on port 1 returns zero with valid and error.
        req1 = 1; addr1 = 30'h40;
        tick();
        idle();
        chk("t5_oor_rvalid1", {31'b0, rvalid1}, 32'd1);
        chk("t5_oor_err1", {31'b0, err1}, 32'd1);
        chk("t5_oor_rdata1", rdata1, 32'd0);
        tick();

        // 6: reset lands on a granted port 1 write of 0x12 @17.
        req0 = 1; addr0 = 30'd3;
        req1 = 1; we1 = 1; addr1 = 30'd17; wdata1 = 32'h12;
        tick();
        req0 = 0;
        #1;
        chk("t6_starve_pre", {29'b0, starve_cnt}, 32'd1);
        chk("t6_gnt1_pre", {31'b0, gnt1}, 32'd1);
        reset = 1;
        #1;
        chk("t6_gnt1_rst", {31'b0, gnt1}, 32'd0);
        chk("t6_mem_wr_rst", {31'b0, mem_wr}, 32'd0);
        chk("t6_starve_rst", {29'b0, starve_cnt}, 32'd0);
        chk("t6_rvalid0_rst", {31'b0, rvalid0}, 32'd0);
        tick();
        chk("t6_flags_rst", {28'b0, err1, err0, rvalid1, rvalid0}, 32'd0);
        idle();
        reset = 0;
        req1 = 1; addr1 = 30'd17;
        #1;
        chk("t6_first_gnt", {31'b0, gnt1}, 32'd1);
        tick();
        idle();
        chk("t6_rvalid1", {31'b0, rvalid1}, 32'd1);
        chk("t6_rdata17", rdata1, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
